// File: rtl/sha_msg_pkg.sv
// Shared constants and state encoding for the SHA message receive path.
package sha_msg_pkg;

    localparam int SHA_WORD_W    = 32;
    localparam int SHA_BLK_WORDS = 16;
    localparam int SHA_BLK_W     = 512;
    localparam int SHA_CNT_W     = $clog2(SHA_BLK_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL
    } rx_state_t;

endpackage

// File: rtl/sha_word_bswap.sv
// Byte reversal of one 32-bit word, used for little-endian host producers.
module sha_word_bswap
    import sha_msg_pkg::*;
(
    input  logic [SHA_WORD_W-1:0] din,
    output logic [SHA_WORD_W-1:0] dout
);

    assign dout = {din[7:0], din[15:8], din[23:16], din[31:24]};

endmodule

// File: rtl/sha_msg_rx.sv
// Collects 16 words into a 512-bit block for the SHA-256 core.
// Define SHA_MSG_RX_BSWAP_EN to byte-reverse each word before it is stored.
//
// state | meaning
// IDLE  | no partial block held
// FILL  | 1..15 words held
// FULL  | 16 words held, block presented on blk_vld
module sha_msg_rx
    import sha_msg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din_vld,
    input  logic [SHA_WORD_W-1:0] din,
    input  logic                  din_sof,
    output logic                  din_rdy,
    output logic                  blk_vld,
    output logic [SHA_BLK_W-1:0]  blk,
    output logic                  blk_init,
    input  logic                  blk_rdy,
    output logic                  err
);

    localparam logic [SHA_CNT_W-1:0] CNT_LAST = SHA_CNT_W'(SHA_BLK_WORDS - 1);

    rx_state_t             state, state_nxt;
    logic [SHA_CNT_W-1:0]  cnt, cnt_nxt;
    logic [SHA_BLK_W-1:0]  blk_q;
    logic [SHA_WORD_W-1:0] word;
    logic                  init_q, init_nxt;
    logic                  err_q, err_nxt;
    logic                  run_q;
    logic                  accept;

`ifdef SHA_MSG_RX_BSWAP_EN
    sha_word_bswap u_bswap (
        .din  (din),
        .dout (word)
    );
`else
    assign word = din;
`endif

    // run_q keeps din_rdy low until the first clock after reset release
    assign din_rdy  = run_q && (state != FULL);
    assign accept   = din_vld && din_rdy;
    assign blk_vld  = (state == FULL);
    assign blk      = blk_q;
    assign blk_init = init_q;
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            blk_q  <= '0;
            init_q <= 1'b0;
            err_q  <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            init_q <= init_nxt;
            err_q  <= err_nxt;
            run_q  <= 1'b1;
            if (accept)
                blk_q <= {blk_q[SHA_BLK_W-SHA_WORD_W-1:0], word};
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        init_nxt  = init_q;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = FILL;
                    cnt_nxt   = SHA_CNT_W'(1);
                    init_nxt  = din_sof;
                end
            end
            FILL: begin
                if (accept) begin
                    // a new message start restarts the block from this word
                    if (din_sof) begin
                        err_nxt  = 1'b1;
                        cnt_nxt  = SHA_CNT_W'(1);
                        init_nxt = 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = FULL;
                    end else begin
                        cnt_nxt = cnt + SHA_CNT_W'(1);
                    end
                end
            end
            FULL: begin
                if (blk_rdy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sha_msg_rx.sv
// Bench for sha_msg_rx: directed scenarios plus random traffic against a queue-based block model.
module tb_sha_msg_rx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         din_vld = 1'b0;
    logic         din_sof = 1'b0;
    logic         blk_rdy = 1'b0;
    logic [31:0]  din = '0;
    logic         din_rdy, blk_vld, blk_init, err;
    logic [511:0] blk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_blk = 0;
    int n_err = 0;

    logic [31:0]  m_q[$];
    bit           m_full, m_rdy, m_err, m_init, m_q_init;
    logic [511:0] m_blk;

`ifdef SHA_MSG_RX_BSWAP_EN
    localparam logic [31:0] SWAP_TOP = 32'h44332211;
`else
    localparam logic [31:0] SWAP_TOP = 32'h11223344;
`endif

    sha_msg_rx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_vld  (din_vld),
        .din      (din),
        .din_sof  (din_sof),
        .din_rdy  (din_rdy),
        .blk_vld  (blk_vld),
        .blk      (blk),
        .blk_init (blk_init),
        .blk_rdy  (blk_rdy),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mw(input logic [31:0] w);
`ifdef SHA_MSG_RX_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    // one clock: pre-edge ready check, edge, model update, post-edge output checks
    task automatic tick();
        bit acc, take;
        chk("din_rdy", din_rdy, m_rdy);
        acc  = din_vld && m_rdy;
        take = m_full && blk_rdy;
        if (blk_vld && blk_rdy) n_blk++;
        @(posedge clk);
        #1;
        m_err = 1'b0;
        if (take) m_full = 1'b0;
        if (acc) begin
            if (din_sof && m_q.size() != 0) begin
                m_err = 1'b1;
                m_q.delete();
            end
            if (m_q.size() == 0) m_q_init = din_sof;
            m_q.push_back(mw(din));
            if (m_q.size() == 16) begin
                m_blk = '0;
                foreach (m_q[i]) m_blk = {m_blk[479:0], m_q[i]};
                m_init = m_q_init;
                m_full = 1'b1;
                m_q.delete();
            end
        end
        m_rdy = !m_full;
        if (err) n_err++;
        chk("blk_vld", blk_vld, m_full);
        chk("err", err, m_err);
        if (m_full) begin
            chk("blk", blk, m_blk);
            chk("blk_init", blk_init, m_init);
        end
    endtask

    task automatic do_reset();
        din_vld = 1'b0;
        din_sof = 1'b0;
        rst_n   = 1'b0;
        m_q.delete();
        m_full = 1'b0;
        m_rdy  = 1'b0;
        m_err  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_din_rdy", din_rdy, 0);
        chk("rst_blk_vld", blk_vld, 0);
        chk("rst_blk", blk, 0);
        chk("rst_blk_init", blk_init, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_word(input logic [31:0] w, input logic sof);
        bit done;
        done    = 1'b0;
        din_vld = 1'b1;
        din     = w;
        din_sof = sof;
        for (int i = 0; i < 64 && !done; i++) begin
            done = m_rdy;
            tick();
        end
        chk("send_accept", done, 1);
    endtask

    task automatic idle(input int n);
        din_vld = 1'b0;
        din_sof = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int nb;
        logic [31:0] w;
        bit acc_last;

        do_reset();

        // single block, continuous
        blk_rdy = 1'b0;
        for (int i = 1; i <= 16; i++) send_word(32'(i), i == 1);
        chk("t1_top", blk[511:480], mw(32'h1));
        chk("t1_bot", blk[31:0], mw(32'h10));
        chk("t1_init", blk_init, 1);
        idle(1);
        blk_rdy = 1'b1;
        idle(1);
        blk_rdy = 1'b0;

        // double-SHA padding block, core stalls for 5 cycles
        for (int i = 0; i < 8; i++) send_word($urandom, i == 0);
        send_word(32'h80000000, 1'b0);
        for (int i = 0; i < 6; i++) send_word(32'h0, 1'b0);
        send_word(32'h00000100, 1'b0);
        din_vld = 1'b1;
        din     = 32'hdeadbeef;
        din_sof = 1'b1;
        repeat (5) tick();
        chk("t2_rdy_low", din_rdy, 0);
        chk("t2_bot", blk[31:0], mw(32'h100));
        din_vld = 1'b0;
        din_sof = 1'b0;
        blk_rdy = 1'b1;
        tick();
        blk_rdy = 1'b0;
        chk("t2_rdy_after", din_rdy, 1);

        // continuation block
        blk_rdy = 1'b1;
        for (int i = 0; i < 16; i++) send_word($urandom, 1'b0);
        chk("t3_init", blk_init, 0);
        idle(2);

        // protocol error on the 6th word
        n_err   = 0;
        blk_rdy = 1'b0;
        for (int i = 1; i <= 21; i++) send_word(32'(i), i == 1 || i == 6);
        chk("t4_err_cnt", n_err, 1);
        chk("t4_top", blk[511:480], mw(32'd6));
        chk("t4_bot", blk[31:0], mw(32'd21));
        chk("t4_init", blk_init, 1);
        blk_rdy = 1'b1;
        idle(2);

        // reset mid-block
        for (int i = 1; i <= 9; i++) send_word(32'(100 + i), i == 1);
        do_reset();
        nb      = n_blk;
        blk_rdy = 1'b0;
        for (int i = 1; i <= 16; i++) send_word(32'(200 + i), i == 1);
        chk("t5_top", blk[511:480], mw(32'd201));
        blk_rdy = 1'b1;
        idle(4);
        chk("t5_blk_cnt", n_blk - nb, 1);

        // byte order of the first word
        blk_rdy = 1'b0;
        send_word(32'h11223344, 1'b1);
        for (int i = 0; i < 15; i++) send_word($urandom, 1'b0);
        chk("t6_top", blk[511:480], SWAP_TOP);
        blk_rdy = 1'b1;
        idle(2);

        // random traffic; producer holds an unaccepted word
        acc_last = 1'b0;
        din_vld  = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!din_vld || acc_last) begin
                din_vld = ($urandom_range(3, 0) != 0);
                w       = $urandom;
                din     = w;
                din_sof = ($urandom_range(7, 0) == 0);
            end
            blk_rdy  = ($urandom_range(1, 0) != 0);
            acc_last = din_vld && m_rdy;
            tick();
        end
        blk_rdy = 1'b1;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
